// File: rtl/psum_accum_buffer_pkg.sv
// -----------------------------------------------------------------------------
// psum_accum_buffer_pkg
// Shared constants and helpers for the partial-sum accumulation buffer.
//   - Default parameter values (row/col width, channel-tile width, Tout,
//     psum width, psum RAM address width, output FIFO depth, afull level).
//   - Width helpers: packed psum vector width, output FIFO entry width.
//   - Saturation bounds used when PSUM_ACCUM_SAT_EN is defined.
// -----------------------------------------------------------------------------
package psum_accum_buffer_pkg;

    localparam int unsigned W_SIZE_DEF      = 8;
    localparam int unsigned W_CHANNEL_DEF   = 4;
    localparam int unsigned TOUT_DEF        = 4;
    localparam int unsigned W_PSUM_DEF      = 16;
    localparam int unsigned BUF_AW_DEF      = 6;
    localparam int unsigned OFIFO_DEPTH_DEF = 4;
    localparam int unsigned AFULL_LVL_DEF   = 2;

    // Width of one packed Tout-lane psum vector.
    function automatic int unsigned psum_vec_w(input int unsigned tout,
                                               input int unsigned w_psum);
        return tout * w_psum;
    endfunction

    // Output FIFO entry: {row, col, psum vector}.
    function automatic int unsigned ofifo_entry_w(input int unsigned w_size,
                                                  input int unsigned vec_w);
        return 2 * w_size + vec_w;
    endfunction

    // Signed saturation bounds of a w-bit two's complement lane.
    function automatic longint psum_sat_hi(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint psum_sat_lo(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/psum_ofifo.sv
// -----------------------------------------------------------------------------
// psum_ofifo
// Synchronous register FIFO holding finished psum vectors.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_push        write request (dropped when full and not popping)
//   i_data        entry to write
//   i_pop         read request (ignored when empty)
//   o_data        head entry (valid when !o_empty)
//   o_empty       FIFO empty
//   o_afull       registered: occupancy >= DEPTH-AFULL_LVL, one cycle behind
//   o_err_ovf     sticky: a push was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module psum_ofifo #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AFULL_LVL = 2,
    parameter int unsigned DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_empty,
    output logic              o_afull,
    output logic              o_err_ovf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT  = (PW + 1)'(DEPTH);
    localparam logic [PW:0] AFULL_CNT = (PW + 1)'(DEPTH - AFULL_LVL);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [PW:0]       r_count;
    logic              r_afull;
    logic              r_err;

    logic w_full;
    logic w_pop;
    logic w_wr;
    logic w_drop;

    assign w_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so push-on-full is legal then.
    assign w_wr    = i_push && (!w_full || w_pop);
    assign w_drop  = i_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_afull <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + (PW + 1)'(w_wr) - (PW + 1)'(w_pop);
            r_afull <= (r_count >= AFULL_CNT);
            if (w_drop) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    assign o_data    = r_mem[r_rptr];
    assign o_afull   = r_afull;
    assign o_err_ovf = r_err;

endmodule

// File: rtl/psum_accum_buffer.sv
// -----------------------------------------------------------------------------
// psum_accum_buffer
// Accumulates PE partial-sum vectors across input-channel tiles in an on-chip
// psum RAM and pushes the finished Tout sums of each pixel into an output FIFO.
// 3-stage pipeline: S0 address + RAM read, S1 RAM data, S2 add/write/push.
// Optional macro PSUM_ACCUM_SAT_EN: lane-wise saturating add instead of wrap.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   c_width, q_channel  frame width, channel tiles per pixel (stable while busy)
//   i_vld, i_row, i_col, i_chn, i_acc_flat   incoming psum vector
//   o_afull             output FIFO almost full (registered)
//   o_vld, i_rdy        output handshake
//   o_row, o_col, o_psum_flat               finished vector (0 when !o_vld)
//   o_err_ovf           sticky: a finished vector was dropped on a full FIFO
// -----------------------------------------------------------------------------
module psum_accum_buffer
    import psum_accum_buffer_pkg::*;
#(
    parameter int unsigned W_SIZE      = W_SIZE_DEF,
    parameter int unsigned W_CHANNEL   = W_CHANNEL_DEF,
    parameter int unsigned Tout        = TOUT_DEF,
    parameter int unsigned W_PSUM      = W_PSUM_DEF,
    parameter int unsigned BUF_AW      = BUF_AW_DEF,
    parameter int unsigned OFIFO_DEPTH = OFIFO_DEPTH_DEF,
    parameter int unsigned AFULL_LVL   = AFULL_LVL_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W_SIZE-1:0]        c_width,
    input  logic [W_SIZE-1:0]        q_channel,
    input  logic                     i_vld,
    input  logic [W_SIZE-1:0]        i_row,
    input  logic [W_SIZE-1:0]        i_col,
    input  logic [W_CHANNEL-1:0]     i_chn,
    input  logic [Tout*W_PSUM-1:0]   i_acc_flat,
    output logic                     o_afull,
    output logic                     o_vld,
    input  logic                     i_rdy,
    output logic [W_SIZE-1:0]        o_row,
    output logic [W_SIZE-1:0]        o_col,
    output logic [Tout*W_PSUM-1:0]   o_psum_flat,
    output logic                     o_err_ovf
);

    localparam int unsigned VEC_W     = psum_vec_w(Tout, W_PSUM);
    localparam int unsigned ENTRY_W   = ofifo_entry_w(W_SIZE, VEC_W);
    localparam int unsigned RAM_DEPTH = 1 << BUF_AW;

`ifdef PSUM_ACCUM_SAT_EN
    localparam logic signed [W_PSUM:0] SAT_HI = (W_PSUM + 1)'(psum_sat_hi(W_PSUM));
    localparam logic signed [W_PSUM:0] SAT_LO = (W_PSUM + 1)'(psum_sat_lo(W_PSUM));
`endif

    function automatic logic [W_PSUM-1:0] lane_add(input logic [W_PSUM-1:0] a,
                                                   input logic [W_PSUM-1:0] b);
`ifdef PSUM_ACCUM_SAT_EN
        logic signed [W_PSUM:0] s;
        s = $signed({a[W_PSUM-1], a}) + $signed({b[W_PSUM-1], b});
        if (s > SAT_HI) begin
            return SAT_HI[W_PSUM-1:0];
        end else if (s < SAT_LO) begin
            return SAT_LO[W_PSUM-1:0];
        end
        return s[W_PSUM-1:0];
`else
        return a + b;
`endif
    endfunction

    // ---------------- S0: address, RAM read, tile flags ----------------
    logic [BUF_AW-1:0] w_addr;
    logic              w_first;
    logic              w_last;

    // Truncating operands first gives the same low BUF_AW bits as the full product.
    assign w_addr  = BUF_AW'(i_row) * BUF_AW'(c_width) + BUF_AW'(i_col);
    assign w_first = (i_chn == '0);
    assign w_last  = (32'(i_chn) == 32'(q_channel) - 32'd1);

    logic [VEC_W-1:0]  r_ram [RAM_DEPTH];
    logic [VEC_W-1:0]  r_rd_data;

    // ---------------- pipeline registers ----------------
    logic              r_s1_vld,   r_s2_vld;
    logic              r_s1_first, r_s2_first;
    logic              r_s1_last,  r_s2_last;
    logic [BUF_AW-1:0] r_s1_addr,  r_s2_addr;
    logic [W_SIZE-1:0] r_s1_row,   r_s2_row;
    logic [W_SIZE-1:0] r_s1_col,   r_s2_col;
    logic [VEC_W-1:0]  r_s1_acc,   r_s2_acc;
    logic [VEC_W-1:0]  r_s2_rdata;

    // Writes of the last two cycles, which the S0 read did not observe.
    logic              r_wb1_vld,  r_wb2_vld;
    logic [BUF_AW-1:0] r_wb1_addr, r_wb2_addr;
    logic [VEC_W-1:0]  r_wb1_data, r_wb2_data;

    logic [VEC_W-1:0]  w_old;
    logic [VEC_W-1:0]  w_sum;
    logic              w_push;
    logic [ENTRY_W-1:0] w_head;
    logic              w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_wb1_vld <= 1'b0;
            r_wb2_vld <= 1'b0;
        end else begin
            r_s1_vld  <= i_vld;
            r_s2_vld  <= r_s1_vld;
            r_wb1_vld <= r_s2_vld;
            r_wb2_vld <= r_wb1_vld;
        end
    end

    always_ff @(posedge clk) begin
        r_s1_first <= w_first;
        r_s1_last  <= w_last;
        r_s1_addr  <= w_addr;
        r_s1_row   <= i_row;
        r_s1_col   <= i_col;
        r_s1_acc   <= i_acc_flat;

        r_s2_first <= r_s1_first;
        r_s2_last  <= r_s1_last;
        r_s2_addr  <= r_s1_addr;
        r_s2_row   <= r_s1_row;
        r_s2_col   <= r_s1_col;
        r_s2_acc   <= r_s1_acc;
        r_s2_rdata <= r_rd_data;

        r_wb1_addr <= r_s2_addr;
        r_wb1_data <= w_sum;
        r_wb2_addr <= r_wb1_addr;
        r_wb2_data <= r_wb1_data;
    end

    // Psum RAM: read-before-write on the same edge, hazards fixed by forwarding.
    always_ff @(posedge clk) begin
        r_rd_data <= r_ram[w_addr];
        if (r_s2_vld) begin
            r_ram[r_s2_addr] <= w_sum;
        end
    end

    // ---------------- S2: forward, accumulate ----------------
    always_comb begin
        w_old = r_s2_rdata;
        if (r_wb1_vld && (r_wb1_addr == r_s2_addr)) begin
            w_old = r_wb1_data;
        end else if (r_wb2_vld && (r_wb2_addr == r_s2_addr)) begin
            w_old = r_wb2_data;
        end
    end

    always_comb begin
        w_sum = r_s2_acc;
        if (!r_s2_first) begin
            for (int g = 0; g < int'(Tout); g++) begin
                w_sum[g*W_PSUM +: W_PSUM] = lane_add(r_s2_acc[g*W_PSUM +: W_PSUM],
                                                     w_old[g*W_PSUM +: W_PSUM]);
            end
        end
    end

    assign w_push = r_s2_vld && r_s2_last;

    psum_ofifo #(
        .DEPTH     (OFIFO_DEPTH),
        .AFULL_LVL (AFULL_LVL),
        .DATA_W    (ENTRY_W)
    ) u_ofifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_data    ({r_s2_row, r_s2_col, w_sum}),
        .i_pop     (i_rdy),
        .o_data    (w_head),
        .o_empty   (w_empty),
        .o_afull   (o_afull),
        .o_err_ovf (o_err_ovf)
    );

    assign o_vld = !w_empty;
    // Zero the fields when empty so stale FIFO storage never leaks out.
    assign {o_row, o_col, o_psum_flat} = o_vld ? w_head : '0;

endmodule

// File: tb/tb_psum_accum_buffer.sv
module tb_psum_accum_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  c_width;
    logic [7:0]  q_channel;
    logic        i_vld;
    logic [7:0]  i_row;
    logic [7:0]  i_col;
    logic [3:0]  i_chn;
    logic [63:0] i_acc_flat;
    logic        o_afull;
    logic        o_vld;
    logic        i_rdy;
    logic [7:0]  o_row;
    logic [7:0]  o_col;
    logic [63:0] o_psum_flat;
    logic        o_err_ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    psum_accum_buffer #(
        .W_SIZE      (8),
        .W_CHANNEL   (4),
        .Tout        (4),
        .W_PSUM      (16),
        .BUF_AW      (6),
        .OFIFO_DEPTH (4),
        .AFULL_LVL   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .c_width     (c_width),
        .q_channel   (q_channel),
        .i_vld       (i_vld),
        .i_row       (i_row),
        .i_col       (i_col),
        .i_chn       (i_chn),
        .i_acc_flat  (i_acc_flat),
        .o_afull     (o_afull),
        .o_vld       (o_vld),
        .i_rdy       (i_rdy),
        .o_row       (o_row),
        .o_col       (o_col),
        .o_psum_flat (o_psum_flat),
        .o_err_ovf   (o_err_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // lane0 in the low bits
    function automatic logic [63:0] pk4(input logic [15:0] l0, input logic [15:0] l1,
                                        input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [63:0] splat(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] c, input logic [3:0] ch,
                         input logic [63:0] acc);
        i_vld      = 1'b1;
        i_row      = r;
        i_col      = c;
        i_chn      = ch;
        i_acc_flat = acc;
        step();
        i_vld      = 1'b0;
    endtask

    task automatic wait_vld(input string tag);
        int n = 0;
        while (!o_vld && n < 20) begin
            step();
            n++;
        end
        chk(tag, 64'(o_vld), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int extra;
        int cnt;

        rst        = 1'b1;
        c_width    = 8'd4;
        q_channel  = 8'd1;
        i_vld      = 1'b0;
        i_row      = '0;
        i_col      = '0;
        i_chn      = '0;
        i_acc_flat = '0;
        i_rdy      = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_vld",   64'(o_vld),     64'd0);
        chk("rst_afull", 64'(o_afull),   64'd0);
        chk("rst_ovf",   64'(o_err_ovf), 64'd0);
        chk("rst_row",   64'(o_row),     64'd0);
        chk("rst_col",   64'(o_col),     64'd0);
        chk("rst_psum",  o_psum_flat,    64'd0);

        // Single tile: latency T+3, fields exact
        drive(8'd1, 8'd2, 4'd0, pk4(16'h0001, 16'hFFFE, 16'h0003, 16'hFFFC));
        chk("t1_lat1", 64'(o_vld), 64'd0);
        step();
        chk("t1_lat2", 64'(o_vld), 64'd0);
        step();
        chk("t1_vld",  64'(o_vld), 64'd1);
        chk("t1_row",  64'(o_row), 64'd1);
        chk("t1_col",  64'(o_col), 64'd2);
        chk("t1_psum", o_psum_flat, 64'hFFFC_0003_FFFE_0001);
        step();
        chk("t1_pop",  64'(o_vld), 64'd0);

        // Three back-to-back tiles of one pixel: forwarding paths
        q_channel = 8'd3;
        drive(8'd0, 8'd0, 4'd0, splat(16'd5));
        drive(8'd0, 8'd0, 4'd1, splat(16'd5));
        drive(8'd0, 8'd0, 4'd2, splat(16'd5));
        wait_vld("t2_vld");
        chk("t2_psum", o_psum_flat, splat(16'd15));
        chk("t2_row",  64'(o_row), 64'd0);
        chk("t2_col",  64'(o_col), 64'd0);
        step();
        extra = 0;
        repeat (6) begin
            if (o_vld) extra++;
            step();
        end
        chk("t2_single", 64'(extra), 64'd0);

        // 4x4 frame, tile 0 (acc 7) then tile 1 (acc -3): 16 raster outputs of 4
        q_channel = 8'd2;
        k = 0;
        fork
            begin
                for (int ch = 0; ch < 2; ch++) begin
                    for (int r = 0; r < 4; r++) begin
                        for (int c = 0; c < 4; c++) begin
                            drive(8'(r), 8'(c), 4'(ch),
                                  (ch == 0) ? splat(16'd7) : splat(16'hFFFD));
                        end
                    end
                end
            end
            begin
                for (int cy = 0; cy < 200 && k < 16; cy++) begin
                    @(negedge clk);
                    if (o_vld) begin
                        chk("t3_row",  64'(o_row), 64'(k / 4));
                        chk("t3_col",  64'(o_col), 64'(k % 4));
                        chk("t3_psum", o_psum_flat, splat(16'd4));
                        k++;
                    end
                end
            end
        join
        chk("t3_count", 64'(k), 64'd16);
        step();

        // Backpressure: afull, overflow drop, drain of exactly 4
        q_channel = 8'd1;
        i_rdy     = 1'b0;
        drive(8'd0, 8'd1, 4'd0, splat(16'd1));
        repeat (5) step();
        chk("t4_afull1", 64'(o_afull), 64'd0);
        drive(8'd1, 8'd1, 4'd0, splat(16'd2));
        repeat (5) step();
        chk("t4_afull2", 64'(o_afull), 64'd1);
        drive(8'd2, 8'd1, 4'd0, splat(16'd3));
        drive(8'd3, 8'd1, 4'd0, splat(16'd4));
        repeat (5) step();
        chk("t4_ovf4",   64'(o_err_ovf), 64'd0);
        drive(8'd4, 8'd1, 4'd0, splat(16'd5));
        repeat (5) step();
        chk("t4_ovf5",   64'(o_err_ovf), 64'd1);
        chk("t4_head",   64'(o_row), 64'd0);
        chk("t4_vld",    64'(o_vld), 64'd1);
        i_rdy = 1'b1;
        cnt = 0;
        for (int cy = 0; cy < 20; cy++) begin
            @(negedge clk);
            if (o_vld) begin
                chk("t4_drow",  64'(o_row), 64'(cnt));
                chk("t4_dpsum", o_psum_flat, splat(16'(cnt + 1)));
                cnt++;
            end
        end
        chk("t4_drained", 64'(cnt), 64'd4);
        step();
        chk("t4_sticky",  64'(o_err_ovf), 64'd1);
        chk("t4_afull0",  64'(o_afull), 64'd0);

        // Two tiles of +/-30000: wrap or clamp
        q_channel = 8'd2;
        drive(8'd2, 8'd3, 4'd0, pk4(16'h7530, 16'h8AD0, 16'h7530, 16'h8AD0));
        drive(8'd2, 8'd3, 4'd1, pk4(16'h7530, 16'h8AD0, 16'h7530, 16'h8AD0));
        wait_vld("t5_vld");
        chk("t5_row", 64'(o_row), 64'd2);
        chk("t5_col", 64'(o_col), 64'd3);
`ifdef PSUM_ACCUM_SAT_EN
        chk("t5_psum", o_psum_flat, pk4(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000));
`else
        // 60000 wraps to -5536, -60000 wraps to 5536
        chk("t5_psum", o_psum_flat, pk4(16'hEA60, 16'h15A0, 16'hEA60, 16'h15A0));
`endif
        step();

        // Reset with two vectors in flight
        q_channel = 8'd1;
        drive(8'd1, 8'd1, 4'd0, splat(16'd9));
        drive(8'd1, 8'd2, 4'd0, splat(16'd9));
        rst = 1'b1;
        step();
        rst = 1'b0;
        extra = 0;
        repeat (6) begin
            if (o_vld) extra++;
            step();
        end
        chk("t6_novld", 64'(extra), 64'd0);
        chk("t6_row",   64'(o_row), 64'd0);
        chk("t6_col",   64'(o_col), 64'd0);
        chk("t6_psum",  o_psum_flat, 64'd0);
        chk("t6_ovf",   64'(o_err_ovf), 64'd0);
        chk("t6_afull", 64'(o_afull), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/psum_accum_buffer.md
Name: psum_accum_buffer

Overview:
- Sits directly downstream of the PE engine. Consumes its per-pixel Tout partial-sum vectors (acc, vld, row, col, channel-tile index).
- Accumulates each vector across all input-channel tiles in an on-chip psum RAM.
- When the last channel tile of a pixel completes, pushes the final Tout sums into an output FIFO with a valid/ready interface toward the post-processing stage.
- Replaces the debug-only psum array now held in the PE engine.

Parameters:
- W_SIZE, `W_SIZE, row/col/width field width
- W_CHANNEL, `W_CHANNEL, channel-tile index width
- Tout, `Tout, psums per vector
- W_PSUM, `W_PSUM, bits per psum (signed two's complement)
- BUF_AW, `BUFFER_ADDRESS_BW, psum RAM address width (depth 2^BUF_AW vectors)
- OFIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
- AFULL_LVL, 2, o_afull asserts when occupancy >= OFIFO_DEPTH-AFULL_LVL

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- c_width  in  W_SIZE  frame width in pixels, stable while busy
- q_channel  in  W_SIZE  number of channel tiles per pixel (>=1)
- i_vld  in  1  PE output valid
- i_row  in  W_SIZE  pixel row
- i_col  in  W_SIZE  pixel column
- i_chn  in  W_CHANNEL  channel-tile index of this vector
- i_acc_flat  in  Tout*W_PSUM  psum g at bits [(g+1)*W_PSUM-1 -: W_PSUM]
- o_afull  out  1  output FIFO almost full; upstream stalls the controller
- o_vld  out  1  final vector valid
- i_rdy  in  1  consumer ready
- o_row, o_col  out  W_SIZE  final vector pixel position
- o_psum_flat  out  Tout*W_PSUM  final sums, same packing
- o_err_ovf  out  1  sticky: push attempted into a full FIFO

Behaviour:
- Reset: one clk with rst high clears all pipeline valids, FIFO pointers and o_err_ovf. After reset: o_vld=0, o_afull=0, o_err_ovf=0, o_row/o_col/o_psum_flat=0. RAM contents are not cleared. Reset mid-operation discards all in-flight vectors.
- Address: addr = i_row*c_width + i_col, truncated to BUF_AW bits.
- Pipeline: 3 stages, one vector per cycle, no input backpressure.
  - S0 (accept cycle T): compute addr, issue synchronous RAM read, register first=(i_chn==0), last=(i_chn==q_channel-1).
  - S1 (T+1): RAM data returns.
  - S2 (T+2):
    - first: sum = i_acc lanes; otherwise sum = old + acc, lane-wise, W_PSUM bits, wrap on overflow.
    - Write sum to RAM.
    - If last, push {row, col, sum} to the FIFO.
- Hazard forwarding: the old operand in S2 is selected by priority:
  - (a) the previous-cycle S2 write to the same address;
  - (b) the write from two cycles earlier to the same address, covering read-during-write at S0;
  - (c) RAM data.
  - Back-to-back same-pixel vectors must accumulate exactly.
- first and last in the same vector (q_channel==1): sum = acc, written to RAM and pushed.
- Output FIFO:
  - o_vld = not empty. Pop when o_vld && i_rdy. Output fields show the head entry combinationally from FIFO registers.
  - Simultaneous push and pop on a full FIFO is legal, with no overflow.
  - Push when full without a pop: the entry is dropped and o_err_ovf is set until rst.
  - o_afull is registered and updates the cycle after the occupancy change.
- Latency: accept at T → o_vld at T+3 when the FIFO was empty.

Optional Feature:
- Macro PSUM_ACCUM_SAT_EN.
- When defined: S2 addition computed in W_PSUM+1 bits and clamped to [-2^(W_PSUM-1), 2^(W_PSUM-1)-1] per lane.
- When undefined: modular W_PSUM-bit wrap.

Decomposition:
- Shared package/header: PSUM_VEC_W = Tout*W_PSUM, lane unpack function, FIFO entry width 2*W_SIZE+PSUM_VEC_W, saturation bounds.
- One sub-module: psum_ofifo (synchronous register FIFO with count, afull, overflow flag). The RAM is an inferred array within psum_accum_buffer.

Test Plan:
- q_channel=1, c_width=4, pixel (1,2), acc lanes {1,-2,3,-4}, i_rdy=1 → o_vld at T+3, row 1, col 2, psum {1,-2,3,-4}.
- q_channel=3, same pixel (0,0) on three consecutive cycles, acc all 5 → single output, all lanes 15 (forwarding path a/b).
- q_channel=2, raster of a 4x4 frame with chn 0 then chn 1 (acc 7 then -3) → 16 outputs in raster order, lanes 4.
- i_rdy=0, OFIFO_DEPTH=4, 5 last-tile vectors → o_afull high after 2; fifth dropped; o_err_ovf=1; then i_rdy=1 drains exactly 4.
- With PSUM_ACCUM_SAT_EN, W_PSUM=16, two tiles of 30000 → 32767. Without it → -5536.
- rst asserted for one cycle while 2 vectors are in flight → no o_vld afterwards; all outputs 0.
